reservation_station: RTL and testbench

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/reservation_station_pkg.sv | 62 ++++++
 rtl/reservation_station_picker.sv | 25 ++
 rtl/reservation_station.sv | 166 ++++++++++++++++
 tb/tb_reservation_station.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// Shared widths, instruction-type codes and entry layout for the reservation station.
// resolve_operand applies the CDB forwarding rule, so issue-time bypass and wakeup share it.
package reservation_station_pkg;

  localparam int RS_SIZE       = 8;
  localparam int RS_INDEX_BIT  = 3;
  localparam int TYPE_BIT      = 4;
  localparam int ROB_INDEX_BIT = 4;

  localparam logic [TYPE_BIT-1:0] TYPE_NOP = 4'd0;
  localparam logic [TYPE_BIT-1:0] TYPE_ADD = 4'd1;
  localparam logic [TYPE_BIT-1:0] TYPE_SUB = 4'd2;
  localparam logic [TYPE_BIT-1:0] TYPE_AND = 4'd3;
  localparam logic [TYPE_BIT-1:0] TYPE_OR  = 4'd4;
  localparam logic [TYPE_BIT-1:0] TYPE_XOR = 4'd5;
  localparam logic [TYPE_BIT-1:0] TYPE_SLL = 4'd6;
  localparam logic [TYPE_BIT-1:0] TYPE_SRL = 4'd7;

  typedef struct packed {
    logic                     busy;
    logic [TYPE_BIT-1:0]      op_type;
    logic [ROB_INDEX_BIT-1:0] rob_id;
    logic [31:0]              vj;
    logic [31:0]              vk;
    logic                     qj_valid;
    logic [ROB_INDEX_BIT-1:0] qj;
    logic                     qk_valid;
    logic [ROB_INDEX_BIT-1:0] qk;
  } rs_entry_t;

  typedef struct packed {
    logic        pending;
    logic [31:0] value;
  } operand_t;

  // The ALU bus wins when both buses carry the tag this operand waits on.
  function automatic operand_t resolve_operand(
    input logic                     pending,
    input logic [ROB_INDEX_BIT-1:0] tag,
    input logic [31:0]              value,
    input logic                     alu_valid,
    input logic [ROB_INDEX_BIT-1:0] alu_tag,
    input logic [31:0]              alu_value,
    input logic                     lsb_valid,
    input logic [ROB_INDEX_BIT-1:0] lsb_tag,
    input logic [31:0]              lsb_value
  );
    operand_t res;
    if (pending && alu_valid && (alu_tag == tag)) begin
      res.pending = 1'b0;
      res.value   = alu_value;
    end else if (pending && lsb_valid && (lsb_tag == tag)) begin
      res.pending = 1'b0;
      res.value   = lsb_value;
    end else begin
      res.pending = pending;
      res.value   = value;
    end
    return res;
  endfunction

endpackage

// File: rtl/reservation_station_picker.sv
// Lowest-index priority picker: reports whether any request bit is set and which one is lowest.
module rs_picker #(
  parameter int N       = 8,
  parameter int IDX_BIT = 3
) (
  input  logic [N-1:0]       req_i,
  output logic               found_o,
  output logic [IDX_BIT-1:0] idx_o
);

  // Scan upward and latch the first set bit.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i] && !found_o) begin
        found_o = 1'b1;
        idx_o   = IDX_BIT'(i);
      end else begin
        found_o = found_o;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: issues into the lowest free slot, wakes operands from two CDBs,
// and dispatches the lowest ready slot to the ALU through registered outputs.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_SIZE      = reservation_station_pkg::RS_SIZE,
  parameter int RS_INDEX_BIT = reservation_station_pkg::RS_INDEX_BIT
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush,
  input  logic                     issue_valid,
  input  logic [TYPE_BIT-1:0]      issue_type,
  input  logic [ROB_INDEX_BIT-1:0] issue_rob_id,
  input  logic [31:0]              issue_vj,
  input  logic [31:0]              issue_vk,
  input  logic                     issue_qj_valid,
  input  logic                     issue_qk_valid,
  input  logic [ROB_INDEX_BIT-1:0] issue_qj,
  input  logic [ROB_INDEX_BIT-1:0] issue_qk,
  output logic                     full,
  input  logic                     cdb_alu_valid,
  input  logic [ROB_INDEX_BIT-1:0] cdb_alu_rob_id,
  input  logic [31:0]              cdb_alu_value,
  input  logic                     cdb_lsb_valid,
  input  logic [ROB_INDEX_BIT-1:0] cdb_lsb_rob_id,
  input  logic [31:0]              cdb_lsb_value,
  output logic                     alu_req,
  output logic [TYPE_BIT-1:0]      alu_type,
  output logic [31:0]              alu_r1,
  output logic [31:0]              alu_r2,
  output logic [ROB_INDEX_BIT-1:0] alu_rob_id
);

  rs_entry_t                entries_q [RS_SIZE];
  rs_entry_t                entries_d [RS_SIZE];
  logic                     alu_req_q, alu_req_d;
  logic [TYPE_BIT-1:0]      alu_type_q, alu_type_d;
  logic [31:0]              alu_r1_q, alu_r1_d;
  logic [31:0]              alu_r2_q, alu_r2_d;
  logic [ROB_INDEX_BIT-1:0] alu_rob_id_q, alu_rob_id_d;

  logic [RS_SIZE-1:0]       free_req;
  logic [RS_SIZE-1:0]       ready_req;
  logic                     free_found, ready_found;
  logic [RS_INDEX_BIT-1:0]  free_idx, ready_idx;
  operand_t                 op_j, op_k;

  // Slot status vectors taken from the state at cycle start.
  always_comb begin
    free_req  = '0;
    ready_req = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      free_req[i]  = ~entries_q[i].busy;
      ready_req[i] = entries_q[i].busy & ~entries_q[i].qj_valid & ~entries_q[i].qk_valid;
    end
  end

  rs_picker #(.N(RS_SIZE), .IDX_BIT(RS_INDEX_BIT)) u_free_picker (
    .req_i   (free_req),
    .found_o (free_found),
    .idx_o   (free_idx)
  );

  rs_picker #(.N(RS_SIZE), .IDX_BIT(RS_INDEX_BIT)) u_ready_picker (
    .req_i   (ready_req),
    .found_o (ready_found),
    .idx_o   (ready_idx)
  );

  assign full = ~free_found;

  // Next state: flush, then wakeup/dispatch/issue when ready; otherwise hold.
  always_comb begin
    entries_d    = entries_q;
    alu_req_d    = alu_req_q;
    alu_type_d   = alu_type_q;
    alu_r1_d     = alu_r1_q;
    alu_r2_d     = alu_r2_q;
    alu_rob_id_d = alu_rob_id_q;
    op_j = resolve_operand(issue_qj_valid, issue_qj, issue_vj,
                           cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value,
                           cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value);
    op_k = resolve_operand(issue_qk_valid, issue_qk, issue_vk,
                           cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value,
                           cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value);
    if (flush) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entries_d[i].busy = 1'b0;
      end
      alu_req_d = 1'b0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (entries_q[i].busy) begin
          {entries_d[i].qj_valid, entries_d[i].vj} = resolve_operand(
              entries_q[i].qj_valid, entries_q[i].qj, entries_q[i].vj,
              cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value,
              cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value);
          {entries_d[i].qk_valid, entries_d[i].vk} = resolve_operand(
              entries_q[i].qk_valid, entries_q[i].qk, entries_q[i].vk,
              cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value,
              cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value);
        end else begin
          entries_d[i] = entries_q[i];
        end
      end
      if (ready_found) begin
        entries_d[ready_idx].busy = 1'b0;
        alu_req_d    = 1'b1;
        alu_type_d   = entries_q[ready_idx].op_type;
        alu_r1_d     = entries_q[ready_idx].vj;
        alu_r2_d     = entries_q[ready_idx].vk;
        alu_rob_id_d = entries_q[ready_idx].rob_id;
      end else begin
        alu_req_d = 1'b0;
      end
      // free_idx is non-busy at cycle start, so it never collides with the dispatched slot.
      if (issue_valid && free_found) begin
        entries_d[free_idx].busy     = 1'b1;
        entries_d[free_idx].op_type  = issue_type;
        entries_d[free_idx].rob_id   = issue_rob_id;
        entries_d[free_idx].vj       = op_j.value;
        entries_d[free_idx].qj_valid = op_j.pending;
        entries_d[free_idx].qj       = issue_qj;
        entries_d[free_idx].vk       = op_k.value;
        entries_d[free_idx].qk_valid = op_k.pending;
        entries_d[free_idx].qk       = issue_qk;
      end else begin
        entries_d[free_idx] = entries_d[free_idx];
      end
    end else begin
      alu_req_d = alu_req_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entries_q[i] <= '0;
      end
      alu_req_q    <= 1'b0;
      alu_type_q   <= '0;
      alu_r1_q     <= 32'd0;
      alu_r2_q     <= 32'd0;
      alu_rob_id_q <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entries_q[i] <= entries_d[i];
      end
      alu_req_q    <= alu_req_d;
      alu_type_q   <= alu_type_d;
      alu_r1_q     <= alu_r1_d;
      alu_r2_q     <= alu_r2_d;
      alu_rob_id_q <= alu_rob_id_d;
    end
  end

  assign alu_req    = alu_req_q;
  assign alu_type   = alu_type_q;
  assign alu_r1     = alu_r1_q;
  assign alu_r2     = alu_r2_q;
  assign alu_rob_id = alu_rob_id_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed, table-driven bench for reservation_station: each row drives one cycle and
// checks the registered ALU outputs and full just after that clock edge.
module tb_reservation_station;
  import reservation_station_pkg::*;

  typedef struct packed {
    logic                     rst;
    logic                     rdy;
    logic                     fl;
    logic                     iv;
    logic [TYPE_BIT-1:0]      itype;
    logic [ROB_INDEX_BIT-1:0] irob;
    logic [31:0]              vj;
    logic [31:0]              vk;
    logic                     qjv;
    logic [ROB_INDEX_BIT-1:0] qj;
    logic                     qkv;
    logic [ROB_INDEX_BIT-1:0] qk;
    logic                     av;
    logic [ROB_INDEX_BIT-1:0] aid;
    logic [31:0]              aval;
    logic                     lv;
    logic [ROB_INDEX_BIT-1:0] lid;
    logic [31:0]              lval;
    logic                     e_req;
    logic                     e_full;
    logic                     chk_data;
    logic [TYPE_BIT-1:0]      e_type;
    logic [31:0]              e_r1;
    logic [31:0]              e_r2;
    logic [ROB_INDEX_BIT-1:0] e_rob;
  } vec_t;

  logic                     clk_in = 1'b0;
  logic                     rst_in, rdy_in, flush;
  logic                     issue_valid;
  logic [TYPE_BIT-1:0]      issue_type;
  logic [ROB_INDEX_BIT-1:0] issue_rob_id;
  logic [31:0]              issue_vj, issue_vk;
  logic                     issue_qj_valid, issue_qk_valid;
  logic [ROB_INDEX_BIT-1:0] issue_qj, issue_qk;
  logic                     full;
  logic                     cdb_alu_valid;
  logic [ROB_INDEX_BIT-1:0] cdb_alu_rob_id;
  logic [31:0]              cdb_alu_value;
  logic                     cdb_lsb_valid;
  logic [ROB_INDEX_BIT-1:0] cdb_lsb_rob_id;
  logic [31:0]              cdb_lsb_value;
  logic                     alu_req;
  logic [TYPE_BIT-1:0]      alu_type;
  logic [31:0]              alu_r1, alu_r2;
  logic [ROB_INDEX_BIT-1:0] alu_rob_id;

  int checks   = 0;
  int failures = 0;
  vec_t tbl[$];

  always #5 clk_in = ~clk_in;

  reservation_station dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rob_id(issue_rob_id),
    .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj_valid(issue_qj_valid), .issue_qk_valid(issue_qk_valid),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .full(full),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_rob_id(cdb_alu_rob_id), .cdb_alu_value(cdb_alu_value),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_rob_id(cdb_lsb_rob_id), .cdb_lsb_value(cdb_lsb_value),
    .alu_req(alu_req), .alu_type(alu_type), .alu_r1(alu_r1), .alu_r2(alu_r2),
    .alu_rob_id(alu_rob_id)
  );

  function automatic vec_t idle();
    vec_t v = '0;
    v.rdy = 1'b1;
    return v;
  endfunction

  function automatic vec_t iss(input vec_t b, input logic [TYPE_BIT-1:0] t,
                               input logic [ROB_INDEX_BIT-1:0] rob,
                               input logic [31:0] vj, input logic [31:0] vk,
                               input logic qjv, input logic [ROB_INDEX_BIT-1:0] qj,
                               input logic qkv, input logic [ROB_INDEX_BIT-1:0] qk);
    vec_t v = b;
    v.iv = 1'b1; v.itype = t; v.irob = rob; v.vj = vj; v.vk = vk;
    v.qjv = qjv; v.qj = qj; v.qkv = qkv; v.qk = qk;
    return v;
  endfunction

  function automatic vec_t alu(input vec_t b, input logic [ROB_INDEX_BIT-1:0] id, input logic [31:0] val);
    vec_t v = b;
    v.av = 1'b1; v.aid = id; v.aval = val;
    return v;
  endfunction

  function automatic vec_t lsb(input vec_t b, input logic [ROB_INDEX_BIT-1:0] id, input logic [31:0] val);
    vec_t v = b;
    v.lv = 1'b1; v.lid = id; v.lval = val;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t b, input logic req, input logic fl);
    vec_t v = b;
    v.e_req = req; v.e_full = fl;
    return v;
  endfunction

  function automatic vec_t exd(input vec_t b, input logic [TYPE_BIT-1:0] t, input logic [31:0] r1,
                               input logic [31:0] r2, input logic [ROB_INDEX_BIT-1:0] rob);
    vec_t v = b;
    v.chk_data = 1'b1; v.e_type = t; v.e_r1 = r1; v.e_r2 = r2; v.e_rob = rob;
    return v;
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%h expected=%h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_in = v.rst; rdy_in = v.rdy; flush = v.fl;
    issue_valid = v.iv; issue_type = v.itype; issue_rob_id = v.irob;
    issue_vj = v.vj; issue_vk = v.vk;
    issue_qj_valid = v.qjv; issue_qj = v.qj; issue_qk_valid = v.qkv; issue_qk = v.qk;
    cdb_alu_valid = v.av; cdb_alu_rob_id = v.aid; cdb_alu_value = v.aval;
    cdb_lsb_valid = v.lv; cdb_lsb_rob_id = v.lid; cdb_lsb_value = v.lval;
  endtask

  task automatic apply(input vec_t v, input int row);
    drive(v);
    @(posedge clk_in);
    #1;
    check("alu_req", row, {31'd0, alu_req}, {31'd0, v.e_req});
    check("full", row, {31'd0, full}, {31'd0, v.e_full});
    if (v.chk_data) begin
      check("alu_type", row, {28'd0, alu_type}, {28'd0, v.e_type});
      check("alu_r1", row, alu_r1, v.e_r1);
      check("alu_r2", row, alu_r2, v.e_r2);
      check("alu_rob_id", row, {28'd0, alu_rob_id}, {28'd0, v.e_rob});
    end
  endtask

  initial begin
    vec_t v;
    bit seen;
    drive(idle());

    // Reset state
    v = idle(); v.rst = 1'b1;
    tbl.push_back(exd(ex(v, 1'b0, 1'b0), TYPE_NOP, 32'd0, 32'd0, 4'd0));
    // Ready at issue: dispatch one edge later, then outputs hold with req low
    tbl.push_back(ex(iss(idle(), TYPE_ADD, 4'd2, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0), 1'b0, 1'b0));
    tbl.push_back(exd(ex(idle(), 1'b1, 1'b0), TYPE_ADD, 32'd5, 32'd7, 4'd2));
    tbl.push_back(exd(ex(idle(), 1'b0, 1'b0), TYPE_ADD, 32'd5, 32'd7, 4'd2));
    // Wakeup on the ALU bus
    tbl.push_back(ex(iss(idle(), TYPE_SUB, 4'd6, 32'd0, 32'd1, 1'b1, 4'd3, 1'b0, 4'd0), 1'b0, 1'b0));
    tbl.push_back(exd(ex(idle(), 1'b0, 1'b0), TYPE_ADD, 32'd5, 32'd7, 4'd2));
    tbl.push_back(ex(alu(idle(), 4'd3, 32'd10), 1'b0, 1'b0));
    tbl.push_back(exd(ex(idle(), 1'b1, 1'b0), TYPE_SUB, 32'd10, 32'd1, 4'd6));
    // Issue-time bypass from the LSB bus
    tbl.push_back(ex(lsb(iss(idle(), TYPE_ADD, 4'd7, 32'd3, 32'd0, 1'b0, 4'd0, 1'b1, 4'd4), 4'd4, 32'h99), 1'b0, 1'b0));
    tbl.push_back(exd(ex(idle(), 1'b1, 1'b0), TYPE_ADD, 32'd3, 32'h99, 4'd7));
    // Both buses match: ALU value wins
    tbl.push_back(ex(iss(idle(), TYPE_AND, 4'd8, 32'd0, 32'd2, 1'b1, 4'd5, 1'b0, 4'd0), 1'b0, 1'b0));
    tbl.push_back(ex(lsb(alu(idle(), 4'd5, 32'h11), 4'd5, 32'h22), 1'b0, 1'b0));
    tbl.push_back(exd(ex(idle(), 1'b1, 1'b0), TYPE_AND, 32'h11, 32'd2, 4'd8));
    // Fill all slots with dependent entries (slot i waits on tag 8+i)
    for (int i = 0; i < 8; i++)
      tbl.push_back(ex(iss(idle(), TYPE_ADD, 4'(i), 32'd0, 32'(i), 1'b1, 4'(8 + i), 1'b0, 4'd0), 1'b0, (i == 7)));
    tbl.push_back(ex(iss(idle(), TYPE_XOR, 4'd15, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0), 1'b0, 1'b1));
    tbl.push_back(ex(alu(idle(), 4'd10, 32'h42), 1'b0, 1'b1));
    tbl.push_back(exd(ex(idle(), 1'b1, 1'b0), TYPE_ADD, 32'h42, 32'd2, 4'd2));
    tbl.push_back(ex(idle(), 1'b0, 1'b0));
    tbl.push_back(ex(iss(idle(), TYPE_SUB, 4'd12, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0), 1'b0, 1'b1));
    tbl.push_back(exd(ex(idle(), 1'b1, 1'b0), TYPE_SUB, 32'd1, 32'd1, 4'd12));
    // Three ready entries, then flush (same-cycle issue ignored)
    tbl.push_back(ex(lsb(alu(iss(idle(), TYPE_ADD, 4'd13, 32'h33, 32'h44, 1'b0, 4'd0, 1'b0, 4'd0), 4'd8, 32'hA0), 4'd9, 32'hB0), 1'b0, 1'b1));
    v = iss(idle(), TYPE_ADD, 4'd14, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0); v.fl = 1'b1;
    tbl.push_back(ex(v, 1'b0, 1'b0));
    tbl.push_back(ex(alu(idle(), 4'd11, 32'hC0), 1'b0, 1'b0));
    tbl.push_back(exd(ex(idle(), 1'b0, 1'b0), TYPE_SUB, 32'd1, 32'd1, 4'd12));
    // rdy_in low for three cycles with a ready entry and CDB pulses
    tbl.push_back(ex(iss(idle(), TYPE_OR, 4'd4, 32'd0, 32'd6, 1'b1, 4'd14, 1'b0, 4'd0), 1'b0, 1'b0));
    tbl.push_back(ex(iss(idle(), TYPE_ADD, 4'd3, 32'h10, 32'h20, 1'b0, 4'd0, 1'b0, 4'd0), 1'b0, 1'b0));
    v = alu(iss(idle(), TYPE_XOR, 4'd9, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0), 4'd14, 32'h77); v.rdy = 1'b0;
    tbl.push_back(ex(v, 1'b0, 1'b0));
    v = idle(); v.rdy = 1'b0;
    tbl.push_back(ex(v, 1'b0, 1'b0));
    v = lsb(idle(), 4'd14, 32'h55); v.rdy = 1'b0;
    tbl.push_back(ex(v, 1'b0, 1'b0));
    tbl.push_back(exd(ex(idle(), 1'b1, 1'b0), TYPE_ADD, 32'h10, 32'h20, 4'd3));
    tbl.push_back(exd(ex(idle(), 1'b0, 1'b0), TYPE_ADD, 32'h10, 32'h20, 4'd3));
    tbl.push_back(ex(alu(idle(), 4'd14, 32'h88), 1'b0, 1'b0));
    tbl.push_back(exd(ex(idle(), 1'b1, 1'b0), TYPE_OR, 32'h88, 32'd6, 4'd4));
    // A pending alu_req is frozen while rdy_in is low
    tbl.push_back(ex(iss(idle(), TYPE_SUB, 4'd9, 32'd2, 32'd3, 1'b0, 4'd0, 1'b0, 4'd0), 1'b0, 1'b0));
    tbl.push_back(exd(ex(idle(), 1'b1, 1'b0), TYPE_SUB, 32'd2, 32'd3, 4'd9));
    v = idle(); v.rdy = 1'b0;
    tbl.push_back(exd(ex(v, 1'b1, 1'b0), TYPE_SUB, 32'd2, 32'd3, 4'd9));
    tbl.push_back(ex(idle(), 1'b0, 1'b0));

    foreach (tbl[i]) apply(tbl[i], i);

    // Reset mid-operation wins over rdy_in low and flush; dropped entries never dispatch
    apply(ex(iss(idle(), TYPE_SUB, 4'd1, 32'd0, 32'd0, 1'b1, 4'd2, 1'b0, 4'd0), 1'b0, 1'b0), 100);
    apply(ex(iss(idle(), TYPE_ADD, 4'd5, 32'd9, 32'd9, 1'b0, 4'd0, 1'b0, 4'd0), 1'b0, 1'b0), 101);
    v = alu(idle(), 4'd7, 32'd1); v.rst = 1'b1; v.rdy = 1'b0; v.fl = 1'b1;
    apply(exd(ex(v, 1'b0, 1'b0), TYPE_NOP, 32'd0, 32'd0, 4'd0), 102);
    apply(ex(alu(idle(), 4'd2, 32'h5), 1'b0, 1'b0), 103);
    apply(exd(ex(idle(), 1'b0, 1'b0), TYPE_NOP, 32'd0, 32'd0, 4'd0), 104);

    // Flush acts even while rdy_in is low
    apply(ex(iss(idle(), TYPE_AND, 4'd6, 32'd4, 32'd0, 1'b0, 4'd0, 1'b1, 4'd3), 1'b0, 1'b0), 105);
    v = idle(); v.rdy = 1'b0; v.fl = 1'b1;
    apply(ex(v, 1'b0, 1'b0), 106);
    apply(ex(alu(idle(), 4'd3, 32'h66), 1'b0, 1'b0), 107);
    apply(ex(idle(), 1'b0, 1'b0), 108);

    // Bounded wait for a fresh dispatch after reset and flush
    drive(iss(idle(), TYPE_XOR, 4'd11, 32'hDEAD0000, 32'h0000BEEF, 1'b0, 4'd0, 1'b0, 4'd0));
    @(posedge clk_in); #1;
    drive(idle());
    seen = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(posedge clk_in); #1;
      if (alu_req) seen = 1'b1;
    end
    check("dispatch_timeout", 200, {31'd0, seen}, 32'd1);
    check("alu_type", 200, {28'd0, alu_type}, {28'd0, TYPE_XOR});
    check("alu_r1", 200, alu_r1, 32'hDEAD0000);
    check("alu_r2", 200, alu_r2, 32'h0000BEEF);
    check("alu_rob_id", 200, {28'd0, alu_rob_id}, 32'd11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
